// File: rtl/wb_wbuf_pkg.sv
// Shared types for the Wishbone posted write buffer.
// Entry layout, FSM states and captured read termination kinds.
package wb_wbuf_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } wr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_GAP,
    RD,
    RD_RSP
  } state_t;

  typedef enum logic [1:0] {
    TERM_ACK,
    TERM_ERR,
    TERM_RTY
  } term_t;

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Write-entry FIFO with a registered head.
// Head is valid whenever count is non-zero.
module wb_wbuf_fifo
  import wb_wbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wr_entry_t     din,
  input  logic          pop,
  output wr_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wr_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // next head is the stored follower, or the incoming entry
      if (do_pop) begin
        if (count > CW'(1)) head <= mem[rd_nxt];
        else if (do_push)   head <= din;
      end else if (empty && do_push) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/wb_posted_write_buffer.sv
// Posted-write buffer between a Wishbone master and a DDR bridge.
// Writes are acked once buffered; reads wait for the buffer to drain.
module wb_posted_write_buffer
  import wb_wbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = 8,
  localparam int SEL_WIDTH = DATA_WIDTH / 8,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [SEL_WIDTH-1:0]  wbs_sel_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  output logic                  wbm_we_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic [LVL_W-1:0]      buf_level,
  output logic                  write_err,
  input  logic                  err_clr
);

  state_t                state;
  state_t                state_nxt;
  wr_entry_t             head;
  wr_entry_t             din;
  logic                  full;
  logic                  empty;
  logic [LVL_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic                  read_pend;
  logic                  any_term;
  logic                  wr_ack_q;
  term_t                 rsp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  unused_burst;

  // burst hints are irrelevant: every beat is handled as a single
  assign unused_burst = ^{wbs_cti_i, wbs_bte_i};

  assign read_pend = wbs_cyc_i & wbs_stb_i & ~wbs_we_i
                   & ~wbs_ack_o & ~wbs_err_o & ~wbs_rty_o;
  assign push      = wbs_cyc_i & wbs_stb_i & wbs_we_i
                   & ~full & ~wbs_ack_o;
  assign any_term  = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign pop       = (state == WR) & (wbm_ack_i | wbm_err_i);
  assign din       = '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};

  wb_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty)         state_nxt = WR;
        else if (read_pend) state_nxt = RD;
      end
      WR: begin
        if (pop)
          state_nxt = (count > LVL_W'(1) || push) ? WR : IDLE;
        else if (wbm_rty_i)
          state_nxt = WR_GAP;
      end
      WR_GAP: state_nxt = WR;
      RD: if (any_term) state_nxt = RD_RSP;
      RD_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbs_ack_o = wr_ack_q;
    wbs_err_o = 1'b0;
    wbs_rty_o = 1'b0;
    unique case (state)
      WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = head.adr;
        wbm_dat_o = head.dat;
        wbm_sel_o = head.sel;
      end
      RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = wbs_adr_i;
        wbm_sel_o = wbs_sel_i;
      end
      RD_RSP: begin
        wbs_ack_o = (rsp_q == TERM_ACK);
        wbs_err_o = (rsp_q == TERM_ERR);
        wbs_rty_o = (rsp_q == TERM_RTY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q <= 1'b0;
      rsp_q    <= TERM_ACK;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ack_q <= push;
      if (state == RD && any_term) begin
        rdata_q <= wbm_dat_i;
        rsp_q   <= wbm_ack_i ? TERM_ACK :
                   wbm_err_i ? TERM_ERR : TERM_RTY;
      end
      // a new error outranks a simultaneous clear
      if (state == WR && wbm_err_i) err_q <= 1'b1;
      else if (err_clr)             err_q <= 1'b0;
    end
  end

  assign wbs_dat_o = rdata_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign buf_level = count;
  assign write_err = err_q;

endmodule

// File: tb/tb_wb_posted_write_buffer.sv
// Self-checking bench for wb_posted_write_buffer.
// A scripted downstream slave logs every master cycle it terminates.
module tb_wb_posted_write_buffer;

  logic        clk;
  logic        rst;
  logic [27:0] s_adr;
  logic [31:0] s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbs_dat_o;
  logic [27:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        ds_ack, ds_err, ds_rty;
  logic [31:0] ds_dat;
  logic [3:0]  buf_level;
  logic        write_err;
  logic        err_clr;

  int tests, fails;
  int cyc_cnt;
  int ds_delay, ds_limit, ds_used;
  int resp_q[$];
  int resp_idx;
  int raw_viol, mcyc;

  typedef struct {
    logic [27:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          term;
    int          edge_n;
  } log_t;

  log_t log_q[$];
  bit [31:0] mem [bit [27:0]];

  wb_posted_write_buffer dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_sel_i(s_sel),
    .wbs_we_i(s_we), .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb),
    .wbs_cti_i(s_cti), .wbs_bte_i(s_bte),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(ds_ack), .wbm_err_i(ds_err), .wbm_rty_i(ds_rty),
    .wbm_dat_i(ds_dat),
    .buf_level(buf_level), .write_err(write_err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // downstream slave: terminates after ds_delay wait cycles
  initial begin
    int cnt;
    int t;
    log_t e;
    bit [31:0] v;
    cnt = 0;
    ds_ack = 1'b0; ds_err = 1'b0; ds_rty = 1'b0; ds_dat = '0;
    forever begin
      @(negedge clk);
      ds_ack = 1'b0; ds_err = 1'b0; ds_rty = 1'b0;
      if (rst || !(wbm_cyc_o && wbm_stb_o)) begin
        cnt = 0;
      end else if ((ds_limit < 0 || ds_used < ds_limit) && cnt >= ds_delay) begin
        t = 0;
        if (resp_idx < resp_q.size()) begin
          t = resp_q[resp_idx];
          resp_idx++;
        end
        ds_used++;
        cnt = 0;
        e.adr = wbm_adr_o; e.dat = wbm_dat_o; e.sel = wbm_sel_o;
        e.we = wbm_we_o; e.term = t; e.edge_n = cyc_cnt + 1;
        log_q.push_back(e);
        if (t == 0) begin
          ds_ack = 1'b1;
          v = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'h0;
          if (wbm_we_o) begin
            for (int b = 0; b < 4; b++)
              if (wbm_sel_o[b]) v[8*b +: 8] = wbm_dat_o[8*b +: 8];
            mem[wbm_adr_o] = v;
          end else begin
            ds_dat = v;
          end
        end else if (t == 1) begin
          ds_err = 1'b1;
        end else begin
          ds_rty = 1'b1;
        end
      end else begin
        cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wbm_cyc_o && !wbm_we_o && buf_level != 4'd0) raw_viol++;
      if (wbm_cyc_o) mcyc++;
    end
  end

  task automatic wb_write(input logic [27:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int n, output bit got);
    s_adr = a; s_dat = d; s_sel = s;
    s_we = 1'b1; s_cyc = 1'b1; s_stb = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      got = wbs_ack_o;
    end
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic wb_read(input logic [27:0] a, input logic [3:0] s,
                         output logic [31:0] d, output bit got, output int aedge);
    int n;
    bit term;
    s_adr = a; s_sel = s; s_dat = '0;
    s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    n = 0; term = 1'b0;
    while (!term && n < 200) begin
      @(posedge clk); #1;
      n++;
      term = wbs_ack_o | wbs_err_o | wbs_rty_o;
    end
    got = wbs_ack_o;
    d = wbs_dat_o;
    aedge = cyc_cnt;
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0;
  endtask

  task automatic wait_drain(input int want_log, output bit ok);
    int n;
    n = 0;
    while ((buf_level != 4'd0 || log_q.size() < want_log || wbm_cyc_o) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 400);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o, wbm_adr_o, wbm_dat_o,
         wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b cyc=%b adr=%h dat=%h required all zero",
               wbs_ack_o, wbm_cyc_o, wbm_adr_o, wbs_dat_o);
    end
    tests++;
    if (buf_level !== 4'd0 || write_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_level: level=%0d err=%b required 0/0", buf_level, write_err);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [27:0] a [3];
    logic [31:0] d [3];
    int base, n, peak;
    bit got, ok;
    a[0] = 28'h10; a[1] = 28'h14; a[2] = 28'h18;
    ds_delay = 5; ds_limit = -1;
    base = log_q.size();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      wb_write(a[i], d[i], 4'hF, n, got);
      tests++;
      if (!got || n !== 1) begin
        fails++;
        $display("FAIL b2b_ack_latency[%0d]: got=%b cycles=%0d required 1", i, got, n);
      end
      if (int'(buf_level) > peak) peak = int'(buf_level);
    end
    wait_drain(base + 3, ok);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (peak !== 3) begin
      fails++;
      $display("FAIL b2b_peak_level: got %0d required 3", peak);
    end
    tests++;
    if (!ok || log_q.size() !== base + 3 || buf_level !== 4'd0) begin
      fails++;
      $display("FAIL b2b_drain: master cycles=%0d level=%0d required 3 and 0",
               log_q.size() - base, buf_level);
    end
    for (int i = 0; i < 3; i++) begin
      if (base + i < log_q.size()) begin
        tests++;
        if (log_q[base+i].adr !== a[i] || log_q[base+i].dat !== d[i] ||
            log_q[base+i].sel !== 4'hF || log_q[base+i].we !== 1'b1) begin
          fails++;
          $display("FAIL b2b_order[%0d]: adr=%h dat=%h we=%b required adr=%h dat=%h we=1",
                   i, log_q[base+i].adr, log_q[base+i].dat, log_q[base+i].we, a[i], d[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [27:0] a [9];
    logic [31:0] d [9];
    logic [3:0]  s [9];
    int base, n, acks;
    bit got, ok;
    ds_delay = 0;
    ds_limit = ds_used;
    base = log_q.size();
    for (int i = 0; i < 9; i++) begin
      a[i] = 28'(32'h40 + 4 * i);
      d[i] = $urandom;
      s[i] = 4'($urandom_range(1, 15));
    end
    for (int i = 0; i < 8; i++) begin
      wb_write(a[i], d[i], s[i], n, got);
      tests++;
      if (!got || n !== 1) begin
        fails++;
        $display("FAIL full_fill_ack[%0d]: got=%b cycles=%0d required 1", i, got, n);
      end
    end
    s_adr = a[8]; s_dat = d[8]; s_sel = s[8];
    s_we = 1'b1; s_cyc = 1'b1; s_stb = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wbs_ack_o) acks++;
    end
    tests++;
    if (acks !== 0 || buf_level !== 4'd8) begin
      fails++;
      $display("FAIL full_stall: acks=%0d level=%0d required 0 and 8", acks, buf_level);
    end
    tests++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== a[0] || wbm_dat_o !== d[0]) begin
      fails++;
      $display("FAIL full_head: cyc=%b adr=%h required 1 and %h", wbm_cyc_o, wbm_adr_o, a[0]);
    end
    ds_limit = ds_used + 1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = wbs_ack_o;
    end
    tests++;
    if (!got || n !== 2) begin
      fails++;
      $display("FAIL full_release_latency: got=%b cycles=%0d required 2", got, n);
    end
    tests++;
    if (buf_level !== 4'd8) begin
      fails++;
      $display("FAIL full_refill_level: got %0d required 8", buf_level);
    end
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    ds_limit = -1;
    wait_drain(base + 9, ok);
    tests++;
    if (!ok || log_q.size() !== base + 9) begin
      fails++;
      $display("FAIL full_drain: master cycles=%0d required 9", log_q.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      if (base + i < log_q.size()) begin
        tests++;
        if (log_q[base+i].adr !== a[i] || log_q[base+i].dat !== d[i] ||
            log_q[base+i].sel !== s[i]) begin
          fails++;
          $display("FAIL full_order[%0d]: adr=%h dat=%h sel=%h required %h %h %h", i,
                   log_q[base+i].adr, log_q[base+i].dat, log_q[base+i].sel, a[i], d[i], s[i]);
        end
      end
    end
  endtask

  task automatic test_raw();
    int base, n, rv0, aedge;
    bit got;
    logic [31:0] rd;
    ds_delay = 3; ds_limit = -1;
    base = log_q.size();
    rv0 = raw_viol;
    wb_write(28'h20, 32'hDEADBEEF, 4'hF, n, got);
    tests++;
    if (!got || n !== 1) begin
      fails++;
      $display("FAIL raw_write_ack: got=%b cycles=%0d required 1", got, n);
    end
    wb_read(28'h20, 4'hF, rd, got, aedge);
    tests++;
    if (!got || rd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL raw_read_data: ack=%b data=%h required 1 and deadbeef", got, rd);
    end
    tests++;
    if (raw_viol !== rv0) begin
      fails++;
      $display("FAIL raw_order: %0d reads with writes pending, required 0", raw_viol - rv0);
    end
    tests++;
    if (log_q.size() < base + 2) begin
      fails++;
      $display("FAIL raw_sequence: master cycles=%0d required 2", log_q.size() - base);
    end else begin
      if (log_q[base].we !== 1'b1 || log_q[base+1].we !== 1'b0 ||
          log_q[base+1].adr !== 28'h20 || log_q[base+1].edge_n <= log_q[base].edge_n) begin
        fails++;
        $display("FAIL raw_sequence: first we=%b second we=%b adr=%h required write then read of 20",
                 log_q[base].we, log_q[base+1].we, log_q[base+1].adr);
      end
      tests++;
      if (aedge !== log_q[base+1].edge_n) begin
        fails++;
        $display("FAIL raw_rsp_latency: slave ack at edge %0d required %0d",
                 aedge, log_q[base+1].edge_n);
      end
    end
  endtask

  task automatic test_retry();
    int base, n;
    bit got, ok;
    logic [31:0] d;
    ds_delay = 0; ds_limit = -1;
    resp_q.push_back(2);
    base = log_q.size();
    d = $urandom;
    wb_write(28'h30, d, 4'h5, n, got);
    n = 0;
    while (log_q.size() == base && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || buf_level !== 4'd1) begin
      fails++;
      $display("FAIL retry_gap: cyc=%b stb=%b level=%0d required 0 0 1",
               wbm_cyc_o, wbm_stb_o, buf_level);
    end
    @(posedge clk); #1;
    tests++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 28'h30 || wbm_dat_o !== d ||
        wbm_sel_o !== 4'h5) begin
      fails++;
      $display("FAIL retry_reissue: cyc=%b adr=%h dat=%h sel=%h required 1 30 %h 5",
               wbm_cyc_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, d);
    end
    wait_drain(base + 2, ok);
    tests++;
    if (!ok || log_q.size() !== base + 2) begin
      fails++;
      $display("FAIL retry_count: master cycles=%0d required 2", log_q.size() - base);
    end else if (log_q[base].term !== 2 || log_q[base+1].term !== 0 ||
                 log_q[base+1].adr !== 28'h30 || log_q[base+1].dat !== d ||
                 log_q[base+1].edge_n - log_q[base].edge_n !== 2) begin
      fails++;
      $display("FAIL retry_count: terms=%0d,%0d spacing=%0d required 2,0 and 2",
               log_q[base].term, log_q[base+1].term,
               log_q[base+1].edge_n - log_q[base].edge_n);
    end
  endtask

  task automatic test_error();
    int n;
    bit got, ok, seen;
    ds_delay = 1; ds_limit = -1;
    tests++;
    if (write_err !== 1'b0) begin
      fails++;
      $display("FAIL err_initial: got %b required 0", write_err);
    end
    resp_q.push_back(1);
    wb_write(28'h34, 32'h12345678, 4'hF, n, got);
    wait_drain(log_q.size(), ok);
    tests++;
    if (!ok || write_err !== 1'b1 || buf_level !== 4'd0) begin
      fails++;
      $display("FAIL err_set: err=%b level=%0d required 1 and 0", write_err, buf_level);
    end
    resp_q.push_back(1);
    wb_write(28'h38, 32'h0BADF00D, 4'hF, n, got);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); #1;
      n++;
      seen = ds_err;
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    tests++;
    if (!seen || write_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set_wins: seen=%b err=%b required 1", seen, write_err);
    end
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    tests++;
    if (write_err !== 1'b0 || buf_level !== 4'd0) begin
      fails++;
      $display("FAIL err_clear: err=%b level=%0d required 0 and 0", write_err, buf_level);
    end
  endtask

  task automatic test_random();
    bit [31:0] mdl [bit [27:0]];
    log_t exp_q[$];
    log_t e;
    int base, n, aedge, k;
    bit got, ok;
    logic [27:0] a;
    logic [31:0] d, want, rd;
    logic [3:0] s;
    ds_limit = -1;
    base = log_q.size();
    for (int i = 0; i < 40; i++) begin
      ds_delay = $urandom_range(0, 3);
      a = 28'(32'h100 + 4 * $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 4) == 0) resp_q.push_back(2);
        wb_write(a, d, s, n, got);
        tests++;
        if (!got) begin
          fails++;
          $display("FAIL rand_write_ack[%0d]: no ack within %0d cycles", i, n);
        end
        want = mdl.exists(a) ? mdl[a] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (s[b]) want[8*b +: 8] = d[8*b +: 8];
        mdl[a] = want;
        e.adr = a; e.dat = d; e.sel = s; e.we = 1'b1; e.term = 0; e.edge_n = 0;
        exp_q.push_back(e);
      end else begin
        s = 4'hF;
        wb_read(a, s, rd, got, aedge);
        want = mdl.exists(a) ? mdl[a] : 32'h0;
        tests++;
        if (!got || rd !== want) begin
          fails++;
          $display("FAIL rand_read[%0d]: adr=%h ack=%b data=%h required %h",
                   i, a, got, rd, want);
        end
      end
    end
    wait_drain(log_q.size(), ok);
    k = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].we && log_q[i].term == 0) begin
        if (k < exp_q.size()) begin
          tests++;
          if (log_q[i].adr !== exp_q[k].adr || log_q[i].dat !== exp_q[k].dat ||
              log_q[i].sel !== exp_q[k].sel) begin
            fails++;
            $display("FAIL rand_write_order[%0d]: adr=%h dat=%h required %h %h",
                     k, log_q[i].adr, log_q[i].dat, exp_q[k].adr, exp_q[k].dat);
          end
        end
        k++;
      end
    end
    tests++;
    if (!ok || k !== exp_q.size()) begin
      fails++;
      $display("FAIL rand_write_count: got %0d required %0d", k, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int n, logsz, mc0;
    bit got;
    ds_delay = 0;
    ds_limit = ds_used;
    for (int i = 0; i < 4; i++)
      wb_write(28'(32'h200 + 4 * i), $urandom, 4'hF, n, got);
    tests++;
    if (buf_level !== 4'd4 || wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1) begin
      fails++;
      $display("FAIL midop_setup: level=%0d cyc=%b we=%b required 4 1 1",
               buf_level, wbm_cyc_o, wbm_we_o);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
         wbm_adr_o, wbm_dat_o, wbm_sel_o, buf_level, write_err} !== '0) begin
      fails++;
      $display("FAIL midop_reset_outputs: cyc=%b adr=%h level=%0d required all zero",
               wbm_cyc_o, wbm_adr_o, buf_level);
    end
    logsz = log_q.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mc0 = mcyc;
    ds_limit = -1;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (mcyc !== mc0 || log_q.size() !== logsz || buf_level !== 4'd0) begin
      fails++;
      $display("FAIL midop_after_release: master cycles=%0d level=%0d required 0 and 0",
               mcyc - mc0, buf_level);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    ds_delay = 0; ds_limit = -1;
    s_adr = '0; s_dat = '0; s_sel = '0;
    s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    s_cti = 3'b000; s_bte = 2'b00;
    err_clr = 1'b0;
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_full();
    test_raw();
    test_retry();
    test_error();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
